// File: rtl/spi_xip_ctrl.sv
// spi_xip_ctrl: APB front end for an SPI master. APB reads inside the flash window run a full
// SPI flash READ (0x03) sequence; other accesses pass through. Optional buffer: SPI_XIP_CACHE_EN.
module spi_xip_ctrl #(
   parameter logic [31:0] FLASH_BASE = 32'h3000_0000,
   parameter logic [31:0] FLASH_END  = 32'h3fff_ffff,
   parameter logic [15:0] SCK_DIV    = 16'd1,
   parameter logic [7:0]  SS_MASK    = 8'h01
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] in_paddr,
   input  logic        in_psel,
   input  logic        in_penable,
   input  logic        in_pwrite,
   input  logic [31:0] in_pwdata,
   input  logic [3:0]  in_pstrb,
   output logic        in_pready,
   output logic [31:0] in_prdata,
   output logic        in_pslverr,
   output logic [4:0]  spi_adr,
   output logic [31:0] spi_wdata,
   input  logic [31:0] spi_rdata,
   output logic [3:0]  spi_sel,
   output logic        spi_we,
   output logic        spi_stb,
   output logic        spi_cyc,
   input  logic        spi_ack,
   input  logic        spi_err,
   output logic        xip_busy
);

   localparam logic [4:0]  ADR_DATA0 = 5'h00;
   localparam logic [4:0]  ADR_TX1   = 5'h04;
   localparam logic [4:0]  ADR_CTRL  = 5'h10;
   localparam logic [4:0]  ADR_DIV   = 5'h14;
   localparam logic [4:0]  ADR_SS    = 5'h18;
   localparam logic [31:0] CTRL_GO   = 32'h0000_0540;

`ifdef SPI_XIP_CACHE_EN
   localparam int AMSB = 31;
`else
   localparam int AMSB = 23;
`endif

   typedef enum logic [3:0] {
      IDLE, PASS, WR_TX1, WR_TX0, WR_DIV, WR_SS, WR_CTRL, POLL, RD_RX, CLR_SS, RESP
   } state_t;

   state_t        state_q;
   logic          stb_q, we_q, pready_q, pslverr_q, busy_q, err_q;
   logic [4:0]    adr_q;
   logic [3:0]    sel_q;
   logic [31:0]   wdata_q, prdata_q, rx_q;
   logic [AMSB:2] addr_q;

   logic          req, in_window, sub_done, pass_done, hit;
   logic [31:0]   hit_word;
   logic [4:0]    step_adr;
   logic [31:0]   step_wdata;
   logic          step_we;

   assign req       = in_psel & in_penable;
   assign in_window = (in_paddr >= FLASH_BASE) && (in_paddr <= FLASH_END);
   assign sub_done  = stb_q & (spi_ack | spi_err);
   assign pass_done = (state_q == PASS) & sub_done;

   // NOTE: every signal gets a default before the case so no latch is inferred.
   always_comb begin
      step_adr   = ADR_DATA0;
      step_wdata = '0;
      step_we    = 1'b1;
      case (state_q)
         WR_TX1:  begin step_adr = ADR_TX1;  step_wdata = {8'h03, addr_q[23:2], 2'b00}; end
         WR_DIV:  begin step_adr = ADR_DIV;  step_wdata = {16'h0, SCK_DIV}; end
         WR_SS:   begin step_adr = ADR_SS;   step_wdata = {24'h0, SS_MASK}; end
         WR_CTRL: begin step_adr = ADR_CTRL; step_wdata = CTRL_GO; end
         POLL:    begin step_adr = ADR_CTRL; step_we = 1'b0; end
         RD_RX:   step_we  = 1'b0;
         CLR_SS:  step_adr = ADR_SS;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         stb_q     <= 1'b0;
         we_q      <= 1'b0;
         adr_q     <= '0;
         sel_q     <= '0;
         wdata_q   <= '0;
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
         prdata_q  <= '0;
         busy_q    <= 1'b0;
         err_q     <= 1'b0;
         rx_q      <= '0;
         addr_q    <= '0;
      end else begin
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
         case (state_q)
            IDLE: if (req) begin
               addr_q <= in_paddr[AMSB:2];
               if (!in_window) begin
                  state_q <= PASS;
                  stb_q   <= 1'b1;
                  adr_q   <= in_paddr[4:0];
                  we_q    <= in_pwrite;
                  wdata_q <= in_pwdata;
                  // reads carry no strobes on APB; the SPI register port needs the full word
                  sel_q   <= in_pwrite ? in_pstrb : 4'hf;
               end else if (in_pwrite || hit) begin
                  state_q   <= RESP;
                  pready_q  <= 1'b1;
                  pslverr_q <= in_pwrite;
                  prdata_q  <= hit ? hit_word : '0;
               end else begin
                  state_q <= WR_TX1;
                  busy_q  <= 1'b1;
                  err_q   <= 1'b0;
               end
            end
            PASS: if (sub_done) begin
               stb_q   <= 1'b0;
               we_q    <= 1'b0;
               state_q <= IDLE;
            end
            RESP: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               if (!stb_q) begin
                  stb_q   <= 1'b1;
                  adr_q   <= step_adr;
                  wdata_q <= step_wdata;
                  we_q    <= step_we;
                  sel_q   <= 4'hf;
               end else if (sub_done) begin
                  stb_q <= 1'b0;
                  we_q  <= 1'b0;
                  if (state_q == CLR_SS) begin
                     state_q   <= RESP;
                     pready_q  <= 1'b1;
                     pslverr_q <= err_q | spi_err;
                     prdata_q  <= (err_q | spi_err) ? '0 :
                                  {rx_q[7:0], rx_q[15:8], rx_q[23:16], rx_q[31:24]};
                  end else if (spi_err) begin
                     err_q   <= 1'b1;
                     state_q <= CLR_SS;
                  end else begin
                     case (state_q)
                        WR_TX1:  state_q <= WR_TX0;
                        WR_TX0:  state_q <= WR_DIV;
                        WR_DIV:  state_q <= WR_SS;
                        WR_SS:   state_q <= WR_CTRL;
                        WR_CTRL: state_q <= POLL;
                        POLL:    if (!spi_rdata[8]) state_q <= RD_RX;
                        RD_RX:   begin rx_q <= spi_rdata; state_q <= CLR_SS; end
                        default: state_q <= IDLE;
                     endcase
                  end
               end
            end
         endcase
      end
   end

`ifdef SPI_XIP_CACHE_EN
   logic        buf_valid_q;
   logic [29:0] buf_tag_q;
   logic [31:0] buf_data_q;

   assign hit      = buf_valid_q && (buf_tag_q == in_paddr[31:2]);
   assign hit_word = {buf_data_q[7:0], buf_data_q[15:8], buf_data_q[23:16], buf_data_q[31:24]};

   // NOTE: only the valid bit is reset; tag and data are ignored until valid is set.
   always_ff @(posedge clk) begin
      if (rst) begin
         buf_valid_q <= 1'b0;
      end else if (state_q == IDLE && req && !in_window && in_pwrite) begin
         buf_valid_q <= 1'b0;
      end else if (state_q == RD_RX && sub_done && !spi_err) begin
         buf_valid_q <= 1'b1;
         buf_tag_q   <= addr_q[31:2];
         buf_data_q  <= spi_rdata;
      end
   end
`else
   assign hit      = 1'b0;
   assign hit_word = '0;
`endif

   // pass-through completes combinationally in the SPI ack cycle
   assign in_pready  = pready_q | pass_done;
   assign in_prdata  = pass_done ? spi_rdata : prdata_q;
   assign in_pslverr = pass_done ? spi_err : pslverr_q;
   assign spi_adr    = adr_q;
   assign spi_wdata  = wdata_q;
   assign spi_sel    = sel_q;
   assign spi_we     = we_q;
   assign spi_stb    = stb_q;
   assign spi_cyc    = stb_q;
   assign xip_busy   = busy_q;

endmodule

// File: tb/tb_spi_xip_ctrl.sv
// Bench for spi_xip_ctrl: SPI master register model, transaction-level reference model,
// table vectors, reset/buffer corner sequences and a randomized run.
module tb_spi_xip_ctrl;

   localparam logic [31:0] FLASH_BASE = 32'h3000_0000;
   localparam logic [31:0] FLASH_END  = 32'h3fff_ffff;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] in_paddr = '0, in_pwdata = '0;
   logic        in_psel = 1'b0, in_penable = 1'b0, in_pwrite = 1'b0;
   logic [3:0]  in_pstrb = '0;
   logic        in_pready, in_pslverr;
   logic [31:0] in_prdata;
   logic [4:0]  spi_adr;
   logic [31:0] spi_wdata;
   logic [31:0] spi_rdata = '0;
   logic [3:0]  spi_sel;
   logic        spi_we, spi_stb, spi_cyc, xip_busy;
   logic        spi_ack = 1'b0, spi_err = 1'b0;

   spi_xip_ctrl dut (
      .clk(clk), .rst(rst),
      .in_paddr(in_paddr), .in_psel(in_psel), .in_penable(in_penable), .in_pwrite(in_pwrite),
      .in_pwdata(in_pwdata), .in_pstrb(in_pstrb), .in_pready(in_pready), .in_prdata(in_prdata),
      .in_pslverr(in_pslverr), .spi_adr(spi_adr), .spi_wdata(spi_wdata), .spi_rdata(spi_rdata),
      .spi_sel(spi_sel), .spi_we(spi_we), .spi_stb(spi_stb), .spi_cyc(spi_cyc),
      .spi_ack(spi_ack), .spi_err(spi_err), .xip_busy(xip_busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [4:0]  adr;
      logic [31:0] wdata;
      logic [3:0]  sel;
      logic [31:0] rdata;
   } acc_t;

   acc_t log_q[$];
   acc_t exp_q[$];
   acc_t mon_a;

   // SPI master register model; acks after ack_lat extra strobe cycles
   logic [31:0] regs [8];
   logic [31:0] rx_word = '0;
   int busy_cnt = 0, polls_cfg = 0, ack_lat = 0, err_k = -1, acc_idx = 0, wait_c = 0, ctrl_reads = 0;

   always @(negedge clk) begin
      if (rst) begin
         spi_ack  = 1'b0;
         spi_err  = 1'b0;
         busy_cnt = 0;
         wait_c   = 0;
         for (int i = 0; i < 8; i++) regs[i] = '0;
      end else if (spi_stb && !spi_ack && !spi_err) begin
         if (wait_c < ack_lat) begin
            wait_c++;
         end else begin
            wait_c      = 0;
            mon_a.we    = spi_we;
            mon_a.adr   = spi_adr;
            mon_a.wdata = spi_wdata;
            mon_a.sel   = spi_sel;
            mon_a.rdata = '0;
            if (spi_we) begin
               regs[spi_adr[4:2]] = spi_wdata;
               if (spi_adr == 5'h10 && spi_wdata[8]) busy_cnt = polls_cfg;
            end else begin
               if (spi_adr == 5'h00) spi_rdata = rx_word;
               else if (spi_adr == 5'h10) begin
                  spi_rdata = (regs[4] & ~32'h100) | ((busy_cnt > 0) ? 32'h100 : 32'h0);
                  if (busy_cnt > 0) busy_cnt--;
                  ctrl_reads++;
               end else spi_rdata = regs[spi_adr[4:2]];
               mon_a.rdata = spi_rdata;
            end
            if (acc_idx == err_k) spi_err = 1'b1;
            else spi_ack = 1'b1;
            acc_idx++;
            log_q.push_back(mon_a);
         end
      end else begin
         spi_ack = 1'b0;
         spi_err = 1'b0;
      end
   end

   int n_cmp = 0, n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] swap_bytes(input logic [31:0] w);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < 4; i++) r[8*(3-i) +: 8] = w[8*i +: 8];
      return r;
   endfunction

   // reference model state for the optional read buffer
   logic        cache_v = 1'b0;
   logic [29:0] cache_tag = '0;
   logic [31:0] cache_data = '0;

   task automatic push_exp(input logic we, input logic [4:0] adr, input logic [31:0] wdata,
                           input logic [3:0] sel);
      acc_t e;
      e.we = we; e.adr = adr; e.wdata = wdata; e.sel = sel; e.rdata = '0;
      exp_q.push_back(e);
   endtask

   task automatic apb_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                           input logic [3:0] strb, output logic ok, output logic err,
                           output logic [31:0] rdata, output int cyc, output logic busy_hi);
      @(negedge clk);
      log_q.delete();
      acc_idx = 0; ctrl_reads = 0;
      in_paddr = addr; in_pwrite = wr; in_pwdata = wdata; in_pstrb = strb;
      in_psel = 1'b1; in_penable = 1'b0;
      @(negedge clk);
      in_penable = 1'b1;
      ok = 1'b0; err = 1'b0; rdata = '0; cyc = 0; busy_hi = 1'b1;
      while (!ok && cyc < 400) begin
         @(negedge clk); #1;
         cyc++;
         if (!xip_busy) busy_hi = 1'b0;
         if (in_pready) begin
            ok = 1'b1; err = in_pslverr; rdata = in_prdata;
         end
      end
      @(posedge clk); #1;
      in_psel = 1'b0; in_penable = 1'b0;
   endtask

   task automatic run_vec(input string tag, input logic [31:0] addr, input logic wr,
                          input logic [31:0] wdata, input logic [3:0] strb, input logic [31:0] rx,
                          input int polls, input int ek, input int lat,
                          output logic got_err, output logic [31:0] got_rd);
      logic in_win, hit, miss, exp_err, ok, busy_hi;
      logic [31:0] exp_rd;
      int exp_cyc, cyc, n;
      in_win = (addr >= FLASH_BASE) && (addr <= FLASH_END);
      hit = 1'b0;
`ifdef SPI_XIP_CACHE_EN
      hit = in_win && !wr && cache_v && (cache_tag == addr[31:2]);
`endif
      miss = in_win && !wr && !hit;
      exp_q.delete();
      exp_rd = '0;
      rx_word = rx; ack_lat = lat;
      polls_cfg = miss ? polls : 0;
      err_k = (miss || !in_win) ? ek : -1;
      if (!in_win) begin
         push_exp(wr, addr[4:0], wdata, wr ? strb : 4'hf);
         exp_err = (ek == 0);
         exp_cyc = lat + 1;
      end else if (wr || hit) begin
         exp_err = wr;
         exp_rd  = swap_bytes(cache_data);
         exp_cyc = 1;
      end else begin
         push_exp(1, 5'h04, 32'h0300_0000 | (addr & 32'h00ff_fffc), 4'hf);
         push_exp(1, 5'h00, 32'h0, 4'hf);
         push_exp(1, 5'h14, 32'h1, 4'hf);
         push_exp(1, 5'h18, 32'h1, 4'hf);
         push_exp(1, 5'h10, 32'h540, 4'hf);
         for (int p = 0; p <= polls; p++) push_exp(0, 5'h10, 32'h0, 4'hf);
         push_exp(0, 5'h00, 32'h0, 4'hf);
         push_exp(1, 5'h18, 32'h0, 4'hf);
         n = exp_q.size();
         if (ek >= 0 && ek < n - 1) begin
            while (exp_q.size() > ek + 1) void'(exp_q.pop_back());
            push_exp(1, 5'h18, 32'h0, 4'hf);
         end
         exp_err = (ek >= 0);
         exp_rd  = swap_bytes(rx);
         exp_cyc = exp_q.size() * (lat + 2) + 1;
      end

      apb_xfer(addr, wr, wdata, strb, ok, got_err, got_rd, cyc, busy_hi);

      check({tag, " done"}, ok, 1);
      check({tag, " pslverr"}, got_err, exp_err);
      if (!in_win && !wr && ek < 0) exp_rd = (log_q.size() != 0) ? log_q[0].rdata : 32'hdead_beef;
      if (!wr && !exp_err) check({tag, " prdata"}, got_rd, exp_rd);
      if (ek < 0) check({tag, " latency"}, cyc, exp_cyc);
      if (miss) check({tag, " xip_busy"}, busy_hi, 1);
      check({tag, " n_acc"}, log_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
         check($sformatf("%s acc%0d we/adr", tag, i), {log_q[i].we, log_q[i].adr},
               {exp_q[i].we, exp_q[i].adr});
         check($sformatf("%s acc%0d sel", tag, i), log_q[i].sel, exp_q[i].sel);
         if (exp_q[i].we) check($sformatf("%s acc%0d wdata", tag, i), log_q[i].wdata, exp_q[i].wdata);
      end

      if (!in_win && wr) cache_v = 1'b0;
      if (miss && (ek < 0 || ek > 6 + polls)) begin
         cache_v = 1'b1; cache_tag = addr[31:2]; cache_data = rx;
      end
   endtask

   typedef struct {
      logic [31:0] addr;
      logic        wr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      logic [31:0] rx;
      int          polls;
      int          ek;
      int          lat;
      logic        chk_rd;
      logic [31:0] exp_rd;
      logic        exp_err;
   } vec_t;

   vec_t tbl[14];

   initial begin
      logic        e;
      logic [31:0] d, a, last_win;
      int          kind, pl, ek, n;

      tbl[0]  = '{32'h1000_0014, 1, 32'h4,         4'hf, 32'h0,         0, -1, 0, 0, 32'h0,         0};
      tbl[1]  = '{32'h1000_0014, 0, 32'h0,         4'h0, 32'h0,         0, -1, 1, 1, 32'h4,         0};
      tbl[2]  = '{32'h3000_0104, 0, 32'h0,         4'h0, 32'h1122_3344, 0, -1, 0, 1, 32'h4433_2211, 0};
      tbl[3]  = '{32'h3000_0200, 0, 32'h0,         4'h0, 32'hdead_beef, 3, -1, 1, 1, 32'hefbe_adde, 0};
      tbl[4]  = '{32'h3000_0000, 1, 32'hffff,      4'hf, 32'h0,         0, -1, 0, 0, 32'h0,         1};
      tbl[5]  = '{32'h30ab_cdef, 0, 32'h0,         4'h0, 32'h0102_0304, 1, -1, 2, 1, 32'h0403_0201, 0};
      tbl[6]  = '{32'h3000_0010, 0, 32'h0,         4'h0, 32'h0,         0,  4, 0, 0, 32'h0,         1};
      tbl[7]  = '{32'h3000_0010, 0, 32'h0,         4'h0, 32'hcafe_f00d, 0, -1, 0, 1, 32'h0df0_feca, 0};
      tbl[8]  = '{32'h2fff_ffff, 0, 32'h0,         4'h0, 32'h0,         0, -1, 0, 1, 32'h0,         0};
      tbl[9]  = '{32'h4000_0000, 0, 32'h0,         4'h0, 32'h55aa_1234, 0, -1, 0, 1, 32'h55aa_1234, 0};
      tbl[10] = '{32'h3fff_fffc, 0, 32'h0,         4'h0, 32'h89ab_cdef, 2, -1, 0, 1, 32'hefcd_ab89, 0};
      tbl[11] = '{32'h1000_0000, 0, 32'h0,         4'h0, 32'h0,         0,  0, 0, 0, 32'h0,         1};
      tbl[12] = '{32'h1000_001c, 1, 32'h1234_5678, 4'h3, 32'h0,         0, -1, 1, 0, 32'h0,         0};
      tbl[13] = '{32'h3000_0104, 0, 32'h0,         4'h0, 32'h1122_3344, 0, -1, 0, 1, 32'h4433_2211, 0};

      repeat (3) @(posedge clk);
      #1;
      check("reset pready", in_pready, 0);
      check("reset pslverr", in_pslverr, 0);
      check("reset prdata", in_prdata, 0);
      check("reset stb/cyc/we", {spi_stb, spi_cyc, spi_we}, 0);
      check("reset adr/sel", {spi_adr, spi_sel}, 0);
      check("reset wdata", spi_wdata, 0);
      check("reset xip_busy", xip_busy, 0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 14; i++) begin
         run_vec($sformatf("vec%0d", i), tbl[i].addr, tbl[i].wr, tbl[i].wdata, tbl[i].strb,
                 tbl[i].rx, tbl[i].polls, tbl[i].ek, tbl[i].lat, e, d);
         check($sformatf("vec%0d table pslverr", i), e, tbl[i].exp_err);
         if (tbl[i].chk_rd) check($sformatf("vec%0d table prdata", i), d, tbl[i].exp_rd);
      end

      // reset while the controller is polling GO_BSY
      @(negedge clk);
      log_q.delete();
      acc_idx = 0; ctrl_reads = 0; rx_word = 32'h1122_3344;
      polls_cfg = 50; ack_lat = 0; err_k = -1;
      in_paddr = 32'h3000_0104; in_pwrite = 1'b0; in_psel = 1'b1; in_penable = 1'b0;
      @(negedge clk);
      in_penable = 1'b1;
      n = 0;
      while (ctrl_reads < 2 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("rst-poll reached POLL", (ctrl_reads >= 2), 1);
      #2 rst = 1'b1;
      @(posedge clk); #1;
      check("rst-poll spi_stb", spi_stb, 0);
      check("rst-poll xip_busy", xip_busy, 0);
      check("rst-poll pready", in_pready, 0);
      @(negedge clk);
      #2;
      in_psel = 1'b0; in_penable = 1'b0; rst = 1'b0;
      cache_v = 1'b0;

      // fresh read, then the same word again (buffer hit when the option is built in)
      run_vec("post-rst read", 32'h3000_0104, 0, 0, 0, 32'h1122_3344, 0, -1, 0, e, d);
      run_vec("repeat read", 32'h3000_0104, 0, 0, 0, 32'h1122_3344, 0, -1, 0, e, d);
      check("repeat read data", d, 32'h4433_2211);

      last_win = 32'h3000_0104;
      for (int i = 0; i < 40; i++) begin
         kind = $urandom_range(0, 3);
         pl   = $urandom_range(0, 3);
         if (kind < 2) begin
            a = $urandom;
            if (a >= FLASH_BASE && a <= FLASH_END) a[31:28] = 4'h7;
            ek = ($urandom_range(0, 7) == 0) ? 0 : -1;
         end else begin
            a = {4'h3, 28'($urandom)};
            if (kind == 3 && $urandom_range(0, 2) == 0) a = last_win;
            if (kind == 3) last_win = a;
            ek = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 7 + pl)) : -1;
         end
         run_vec($sformatf("rnd%0d", i), a, (kind == 0 || kind == 2), $urandom, 4'($urandom),
                 $urandom, pl, ek, $urandom_range(0, 2), e, d);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/spi_xip_ctrl.md
Name: spi_xip_ctrl

Overview:
- Sits between the APB bus and the SPI master's register port; turns each APB read in the flash window into a full SPI flash READ (0x03) transaction.
- APB accesses outside the flash window pass straight through to the SPI master registers, so software can still program the SPI master by hand.
- Sequences the SPI master itself: loads TX, divider, slave-select and control, polls GO_BSY, fetches RX, then deselects.

Parameters:
- FLASH_BASE, 32'h30000000, first byte address of the XIP window.
- FLASH_END, 32'h3fffffff, last byte address of the XIP window.
- SCK_DIV, 16'd1, value written to the SPI DIVIDER register before each XIP transfer.
- SS_MASK, 8'h01, value written to the SPI SS register to select the flash.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_paddr  in  32  APB address.
- in_psel  in  1  APB select.
- in_penable  in  1  APB enable.
- in_pwrite  in  1  APB write.
- in_pwdata  in  32  APB write data.
- in_pstrb  in  4  APB byte strobes.
- in_pready  out  1  APB ready, one-cycle pulse.
- in_prdata  out  32  APB read data.
- in_pslverr  out  1  APB error, valid with in_pready.
- spi_adr  out  5  SPI register byte address.
- spi_wdata  out  32  SPI register write data.
- spi_rdata  in  32  SPI register read data.
- spi_sel  out  4  SPI byte select.
- spi_we  out  1  SPI write enable.
- spi_stb  out  1  SPI strobe.
- spi_cyc  out  1  SPI cycle.
- spi_ack  in  1  SPI acknowledge.
- spi_err  in  1  SPI error.
- xip_busy  out  1  high while an XIP sequence is in progress.

Behaviour:
- Reset: state IDLE; in_pready=0, in_pslverr=0, in_prdata=0, spi_stb=spi_cyc=spi_we=0, spi_adr=0, spi_wdata=0, spi_sel=0, xip_busy=0.
- SPI register map: TX0/RX0=0x00, TX1=0x04, CTRL=0x10, DIVIDER=0x14, SS=0x18.
- CTRL bits: GO_BSY=bit8, TX_NEG=bit10, CHAR_LEN=[6:0], where 0 means 128 bits.
- Request: an APB request is accepted in IDLE when in_psel&in_penable.
- The flash window test is FLASH_BASE<=in_paddr<=FLASH_END (unsigned); in_paddr is latched on acceptance.
- SPI sub-access: spi_stb=spi_cyc=1 held until spi_ack; all spi_* outputs are stable while held. After ack, strobe is low for at least one cycle before the next sub-access.
- Any spi_err during a sub-access aborts the sequence: SS is cleared, then the APB access completes with in_pslverr=1.
- PASS (request outside window):
  - spi_adr=in_paddr[4:0]; spi_wdata, spi_sel and spi_we follow the APB inputs.
  - in_pready=spi_ack and in_prdata=spi_rdata in the ack cycle; in_pslverr=spi_err.
  - Next state IDLE.
- Write inside window: no SPI activity; in_pready=1 with in_pslverr=1 in the cycle after acceptance.
- XIP read inside window; each step below is one sub-access (writes unless noted):
  - WR_TX1: {8'h03, addr[23:0]} to 0x04.
  - WR_TX0: 0 to 0x00.
  - WR_DIV: {16'h0, SCK_DIV} to 0x14.
  - WR_SS: {24'h0, SS_MASK} to 0x18.
  - WR_CTRL: 32'h0000_0540 to 0x10 (CHAR_LEN=64, TX_NEG=1, GO=1).
  - POLL: read 0x10; if rdata[8]=1, repeat POLL; else go to RD_RX.
  - RD_RX: read 0x00 and latch rdata.
  - CLR_SS: 0 to 0x18.
  - RESP: in_pready=1 for one cycle, in_prdata = the latched word byte-swapped ({b0,b1,b2,b3}), in_pslverr=0. Next state IDLE.
- addr[1:0] is ignored; the transfer always fetches the aligned word at addr[23:2],2'b00.
- xip_busy is high from WR_TX1 through RESP inclusive.
- Minimum XIP latency with spi_ack in the cycle after strobe and a single POLL: 8 sub-accesses × 2 cycles + RESP.
- New APB requests are not sampled outside IDLE; the bus holds psel/penable until in_pready.
- Reset mid-sequence: return to IDLE next cycle with strobe low. The SPI master is reset by the same rst, so SS is cleared there.

Optional Feature:
- Macro SPI_XIP_CACHE_EN.
- When defined: a one-entry read buffer (valid bit, tag = addr[31:2], data word).
  - On an XIP read hit, respond in the cycle after acceptance with no SPI activity.
  - A miss runs the full sequence and refills the buffer.
  - Reset, or any PASS write, clears valid.
- When undefined: every XIP read runs the full sequence; no buffer storage exists.

Test Plan:
- Pass-through: APB write 0x3000_0000? No, write 0x1000_0014 data 0x0000_0004 -> spi_adr=0x14, spi_we=1, spi_wdata=4; in_pready in the spi_ack cycle; pslverr=0.
- XIP read at 0x3000_0104, SPI model RX0=0x11223344 -> TX1 written 0x03000104, CTRL 0x540, SS 0x01 then 0x00; in_prdata=0x44332211.
- POLL: GO_BSY reads 1 three times, then 0 -> exactly 4 CTRL reads before the RX0 read; xip_busy stays high throughout.
- APB write to 0x3000_0000 -> in_pslverr=1, in_pready 1 cycle after acceptance, no spi_stb.
- spi_err injected on WR_CTRL -> SS write 0 is issued, then in_pslverr=1; next request is served normally.
- rst asserted during POLL -> next cycle spi_stb=0, xip_busy=0, state IDLE. With SPI_XIP_CACHE_EN, a repeat read of 0x3000_0104 returns 0x44332211 with zero SPI accesses.
